// File: rtl/chain_pkg.sv
// Shared definitions for blocks that sit on the 8-bit processing chain.
package chain_pkg;
   localparam int unsigned CHAIN_W    = 8;
   localparam int unsigned DROP_CNT_W = 16;

   typedef logic [CHAIN_W-1:0] chain_byte_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output and full-with-pop acceptance.
// level counts every stored entry, including the one presented on rd_data.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   wr_ok,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [LW-1:0]    rem;
   logic [LW-1:0]    level_nxt;
   logic             pop;
   logic             push;

   // Handshake decode, acceptance and next occupancy.
   always_comb begin
      pop        = rd_valid && rd_ready;
      push       = wr_en && ((level < FULL_LVL) || pop);
      rd_ptr_nxt = rd_ptr + PW'(pop);
      rem        = level - LW'(pop);
      level_nxt  = rem + LW'(push);
   end

   assign wr_ok = push;

   // Storage write; contents need no reset since pointers and level gate visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, level and registered head.
   // When nothing older remains after a pop, the head comes straight from the
   // write port; otherwise it is the stored entry at the advanced read pointer,
   // which can never be the slot being written this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         wr_ptr   <= wr_ptr + PW'(push);
         rd_ptr   <= rd_ptr_nxt;
         level    <= level_nxt;
         rd_valid <= (level_nxt != '0);
         if (rem == '0) begin
            if (push) begin
               rd_data <= wr_data;
            end
         end else begin
            rd_data <= mem[rd_ptr_nxt];
         end
      end
   end
endmodule

// File: rtl/chain_capture.sv
// Samples the chain output byte into a FIFO, optionally only on change,
// and keeps a sticky overflow flag with a saturating drop counter.
module chain_capture
   import chain_pkg::*;
#(
   parameter int unsigned WIDTH       = CHAIN_W,
   parameter int unsigned DEPTH       = 16,
   parameter bit          CHANGE_ONLY = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        in,
   input  logic                    sample_en,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic [DROP_CNT_W-1:0]   drop_count,
   input  logic                    clear_ovf
);
   logic             have_last;
   logic [WIDTH-1:0] last_acc;
   logic             cand;
   logic             acc;
   logic             drop;

   // Push candidate after change filtering; an unaccepted candidate is a drop.
   always_comb begin
      cand = sample_en && (!CHANGE_ONLY || !have_last || (in != last_acc));
      drop = cand && !acc;
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (cand),
      .wr_data  (in),
      .wr_ok    (acc),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .rd_ready (out_ready),
      .level    (level)
   );

   // Remember the last accepted sample for the change filter.
   always_ff @(posedge clk) begin
      if (rst) begin
         have_last <= 1'b0;
         last_acc  <= '0;
      end else if (acc) begin
         have_last <= 1'b1;
         last_acc  <= in;
      end
   end

   // Sticky overflow and saturating drop count; a drop coinciding with a clear counts as the first new drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_ovf) begin
         overflow   <= drop;
         drop_count <= drop ? DROP_CNT_W'(1) : '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_chain_capture.sv
// Testbench for chain_capture: table vectors, directed corner sequences and
// a randomized phase against a queue-based reference model. Two instances run
// side by side, one plain and one with change-only filtering.
module tb_chain_capture;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_en;
   logic        out_ready;
   logic        clear_ovf;
   logic [7:0]  din;

   logic [7:0]  d0_data, d1_data;
   logic        d0_valid, d1_valid;
   logic [4:0]  d0_level, d1_level;
   logic        d0_ovf, d1_ovf;
   logic [15:0] d0_dc, d1_dc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chain_capture #(.WIDTH(8), .DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in(din), .sample_en(sample_en),
      .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
      .level(d0_level), .overflow(d0_ovf), .drop_count(d0_dc), .clear_ovf(clear_ovf));

   chain_capture #(.WIDTH(8), .DEPTH(DEPTH), .CHANGE_ONLY(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in(din), .sample_en(sample_en),
      .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
      .level(d1_level), .overflow(d1_ovf), .drop_count(d1_dc), .clear_ovf(clear_ovf));

   // ---------------- reference model (index 0: plain, 1: change-only) -----
   logic [7:0]  mq0[$];
   logic [7:0]  mq1[$];
   logic        m_ovf[2];
   logic [15:0] m_dc[2];
   logic        m_hl[2];
   logic [7:0]  m_la[2];
   logic [7:0]  m_shown[2];

   function automatic int msize(int m);
      return (m == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [7:0] mhead(int m);
      return (m == 0) ? mq0[0] : mq1[0];
   endfunction

   task automatic mpush(int m, logic [7:0] v);
      if (m == 0) mq0.push_back(v); else mq1.push_back(v);
   endtask

   task automatic mpop(int m);
      logic [7:0] t;
      if (m == 0) t = mq0.pop_front(); else t = mq1.pop_front();
   endtask

   task automatic model_update();
      bit pop, cand, acc;
      if (rst) begin
         mq0.delete();
         mq1.delete();
         for (int m = 0; m < 2; m++) begin
            m_ovf[m] = 1'b0; m_dc[m] = '0; m_hl[m] = 1'b0;
            m_la[m] = '0; m_shown[m] = '0;
         end
         return;
      end
      for (int m = 0; m < 2; m++) begin
         pop  = (msize(m) > 0) && out_ready;
         cand = sample_en && (m == 0 || !m_hl[m] || din != m_la[m]);
         acc  = cand && (msize(m) < DEPTH || pop);
         if (pop) mpop(m);
         if (acc) begin
            mpush(m, din);
            m_hl[m] = 1'b1;
            m_la[m] = din;
         end
         if (clear_ovf) begin
            m_ovf[m] = 1'b0;
            m_dc[m]  = '0;
         end
         if (cand && !acc) begin
            m_ovf[m] = 1'b1;
            if (m_dc[m] != 16'hFFFF) m_dc[m] = m_dc[m] + 16'd1;
         end
         if (msize(m) > 0) m_shown[m] = mhead(m);
      end
   endtask

   // ---------------- checking helpers -------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("m0.valid", 32'(d0_valid), 32'(msize(0) > 0));
      chk("m0.data",  32'(d0_data),  32'(m_shown[0]));
      chk("m0.level", 32'(d0_level), 32'(msize(0)));
      chk("m0.ovf",   32'(d0_ovf),   32'(m_ovf[0]));
      chk("m0.dc",    32'(d0_dc),    32'(m_dc[0]));
      chk("m1.valid", 32'(d1_valid), 32'(msize(1) > 0));
      chk("m1.data",  32'(d1_data),  32'(m_shown[1]));
      chk("m1.level", 32'(d1_level), 32'(msize(1)));
      chk("m1.ovf",   32'(d1_ovf),   32'(m_ovf[1]));
      chk("m1.dc",    32'(d1_dc),    32'(m_dc[1]));
   endtask

   // One clock: model consumes the same inputs the DUT samples, then compare.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic drive(logic r, logic se, logic [7:0] d, logic rdy, logic clr);
      rst = r; sample_en = se; din = d; out_ready = rdy; clear_ovf = clr;
      step();
   endtask

   // ---------------- table vectors ----------------------------------------
   typedef struct {
      logic        r, se;
      logic [7:0]  d;
      logic        rdy, clr;
      logic        ev;
      logic [7:0]  ed;
      logic [4:0]  el;
      logic        eo;
      logic [15:0] ec;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b0, 16'd0};
      tbl[4] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 5'd1, 1'b0, 16'd0};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 5'd1, 1'b0, 16'd0};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3, 5'd0, 1'b0, 16'd0};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 5'd0, 1'b0, 16'd0};

      rst = 1'b1; sample_en = 1'b0; din = '0; out_ready = 1'b0; clear_ovf = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].r, tbl[i].se, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk("tbl.valid", 32'(d0_valid), 32'(tbl[i].ev));
         chk("tbl.data",  32'(d0_data),  32'(tbl[i].ed));
         chk("tbl.level", 32'(d0_level), 32'(tbl[i].el));
         chk("tbl.ovf",   32'(d0_ovf),   32'(tbl[i].eo));
         chk("tbl.dc",    32'(d0_dc),    32'(tbl[i].ec));
      end

      // Fill past capacity with no reader, then drain in order.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill.level", 32'(d0_level), 32'd16);
      chk("fill.ovf",   32'(d0_ovf),   32'd1);
      chk("fill.dc",    32'(d0_dc),    32'd4);
      for (int i = 0; i < 16; i++) begin
         chk("drain.valid", 32'(d0_valid), 32'd1);
         chk("drain.data",  32'(d0_data),  32'(i));
         drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain.empty", 32'(d0_valid), 32'd0);

      // Full FIFO with a pop every cycle still accepts the new sample.
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(32'h20 + i), 1'b0, 1'b0);
      chk("full.level", 32'(d0_level), 32'd16);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
         chk("fullpop.level", 32'(d0_level), 32'd16);
         chk("fullpop.dc",    32'(d0_dc),    32'd4);
      end
      for (int i = 0; i < 16; i++) begin
         chk("fullpop.order", 32'(d0_data), (i < 11) ? 32'h25 + 32'(i) : 32'h55);
         drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("fullpop.empty", 32'(d0_level), 32'd0);

      // Change-only filtering: 3,3,3,7,7,3 yields 3,7,3.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      begin
         logic [7:0] seq [6];
         logic [7:0] exp_co [3];
         seq = '{8'd3, 8'd3, 8'd3, 8'd7, 8'd7, 8'd3};
         exp_co = '{8'd3, 8'd7, 8'd3};
         for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, seq[i], 1'b0, 1'b0);
         chk("co.level",   32'(d1_level), 32'd3);
         chk("co.dc",      32'(d1_dc),    32'd0);
         chk("plain.level", 32'(d0_level), 32'd6);
         for (int i = 0; i < 3; i++) begin
            chk("co.data", 32'(d1_data), 32'(exp_co[i]));
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         end
         chk("co.empty", 32'(d1_valid), 32'd0);
      end

      // Drop colliding with clear_ovf, then clear alone.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(32'h40 + i), 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
      chk("clr.coll.ovf", 32'(d0_ovf), 32'd1);
      chk("clr.coll.dc",  32'(d0_dc),  32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr.ovf",   32'(d0_ovf),   32'd0);
      chk("clr.dc",    32'(d0_dc),    32'd0);
      chk("clr.level", 32'(d0_level), 32'd16);

      // Reset in the middle of a backpressured stream.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(32'h61 + i), 1'b0, 1'b0);
      chk("mid.level", 32'(d0_level), 32'd9);
      chk("mid.head",  32'(d0_data),  32'h3C);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst.valid", 32'(d0_valid), 32'd0);
      chk("rst.level", 32'(d0_level), 32'd0);
      chk("rst.data",  32'(d0_data),  32'd0);
      drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
      chk("rst.push.valid", 32'(d0_valid), 32'd1);
      chk("rst.push.data",  32'(d0_data),  32'h11);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 3) != 0),
               8'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 15) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
